uart_receive_fifo: RTL and testbench

- Parametrised next-generation UART receiver.
- Configurable data width, parity mode and stop-bit count.
- Received words go into an internal FIFO, drained by a ready/valid handshake.
- Flags parity errors per word; pulses framing and overrun errors. Sits between the board RX pin and the downstream command/packet parser.

---
 rtl/uart_receive_fifo.sv | 202 ++++++++++++++++++++
 tb/tb_uart_receive_fifo.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receive_fifo.sv
// uart_receive_fifo: UART receiver (configurable width, parity, stop bits)
// feeding a small receive FIFO drained by a ready/valid handshake.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around mid-bit.
module uart_receive_fifo #(
    parameter int unsigned INPUT_CLOCK_FREQ = 100_000_000,
    parameter int unsigned BAUD_RATE        = 9600,
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned PARITY           = 0,
    parameter int unsigned STOP_BITS        = 1,
    parameter int unsigned FIFO_DEPTH       = 4
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rx_wire_in,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          parity_err_out,
    output logic                          valid_out,
    input  logic                          ready_in,
    output logic                          frame_err_out,
    output logic                          overrun_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);

    localparam int unsigned BIT_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_BIT   = BIT_PERIOD / 2;
    localparam int unsigned CNT_W      = $clog2(BIT_PERIOD);
    localparam int unsigned IDX_W      = $clog2(DATA_WIDTH);
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_FW     = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK, S_PUSH
    } state_t;

    state_t                state;
    logic                  rx_meta;
    logic                  rx_s;
    logic [CNT_W-1:0]      bit_cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic                  stop_idx;
    logic [DATA_WIDTH-1:0] shift;
    logic                  perr;
    logic                  sample_bit;
    logic                  sample_tick;

    logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      rd_next;
    logic [CNT_FW-1:0]     count_next;
    logic                  pop;
    logic                  full;
    logic                  push;
    logic [DATA_WIDTH-1:0] head_word;
    logic                  head_perr;

    // Two-flop synchroniser, preset to the idle line level
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_wire_in;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned SAMPLE_AT = HALF_BIT + 1;
    logic [1:0] hist;

    // Keep the two previous synchronised samples for the 2-of-3 vote
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) hist <= 2'b11;
        else        hist <= {hist[0], rx_s};
    end

    assign sample_bit = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    localparam int unsigned SAMPLE_AT = HALF_BIT;

    assign sample_bit = rx_s;
`endif

    assign sample_tick = (bit_cnt == CNT_W'(SAMPLE_AT));

    // FIFO bookkeeping and next head word, including write-through into an empty FIFO
    always_comb begin
        pop        = valid_out && ready_in;
        full       = (fifo_count_out == CNT_FW'(FIFO_DEPTH));
        push       = (state == S_PUSH) && (!full || pop);
        rd_next    = rd_ptr + PTR_W'(pop);
        count_next = fifo_count_out + CNT_FW'(push) - CNT_FW'(pop);
        head_word  = '0;
        head_perr  = 1'b0;
        if (count_next != '0) begin
            if (push && (fifo_count_out == CNT_FW'(pop)))
                {head_perr, head_word} = {perr, shift};
            else
                {head_perr, head_word} = mem[rd_next];
        end
    end

    // Receive FSM: start detection, bit sampling, parity/stop checks, push request
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state         <= S_IDLE;
            bit_cnt       <= '0;
            bit_idx       <= '0;
            stop_idx      <= 1'b0;
            shift         <= '0;
            perr          <= 1'b0;
            frame_err_out <= 1'b0;
            overrun_out   <= 1'b0;
        end else begin
            frame_err_out <= 1'b0;
            overrun_out   <= 1'b0;
            if (bit_cnt == CNT_W'(BIT_PERIOD - 1)) bit_cnt <= '0;
            else                                   bit_cnt <= bit_cnt + CNT_W'(1);
            case (state)
                S_IDLE: begin
                    bit_cnt <= '0;
                    if (!rx_s) state <= S_START;
                end
                S_START: begin
                    if (sample_tick) begin
                        if (sample_bit) begin
                            state <= S_IDLE;
                        end else begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                            perr    <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (sample_tick) begin
                        shift[bit_idx] <= sample_bit;
                        if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
                            state    <= (PARITY != 0) ? S_PARITY : S_STOP;
                            stop_idx <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (sample_tick) begin
                        if (PARITY == 1) perr <= ~((^shift) ^ sample_bit);
                        else             perr <= (^shift) ^ sample_bit;
                        state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (sample_tick) begin
                        if (!sample_bit) begin
                            frame_err_out <= 1'b1;
                            state         <= S_BREAK;
                        end else if (stop_idx == 1'(STOP_BITS - 1)) begin
                            state <= S_PUSH;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                S_BREAK: begin
                    if (rx_s) state <= S_IDLE;
                end
                S_PUSH: begin
                    overrun_out <= !push;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // FIFO pointers, occupancy and registered head outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count_out <= '0;
            valid_out      <= 1'b0;
            data_out       <= '0;
            parity_err_out <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr         <= rd_next;
            fifo_count_out <= count_next;
            valid_out      <= (count_next != '0);
            data_out       <= head_word;
            parity_err_out <= head_perr;
        end
    end

    // FIFO storage; contents are only meaningful behind the pointers
    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr] <= {perr, shift};
    end

endmodule

// File: tb/tb_uart_receive_fifo.sv
// Bench for uart_receive_fifo: one no-parity/1-stop instance and one
// even-parity/2-stop instance, scoreboard queues checked by per-DUT monitors.
module tb_uart_receive_fifo;

    localparam int BIT_CYC = 100;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       rx0, rx1;
    logic       ready0, ready1;
    logic [7:0] data0, data1;
    logic       perr0, perr1;
    logic       valid0, valid1;
    logic       fe0, fe1;
    logic       ov0, ov1;
    logic [2:0] count0, count1;

    int checks = 0;
    int errors = 0;
    int fe_cnt0 = 0, fe_cnt1 = 0;
    int ov_cnt0 = 0, ov_cnt1 = 0;

    logic [8:0] exp0[$];
    logic [8:0] exp1[$];

    always #5 clk_in = ~clk_in;

    uart_receive_fifo #(
        .INPUT_CLOCK_FREQ(100_000_000), .BAUD_RATE(1_000_000), .DATA_WIDTH(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_nopar (
        .clk_in(clk_in), .rst_in(rst_in), .rx_wire_in(rx0),
        .data_out(data0), .parity_err_out(perr0), .valid_out(valid0),
        .ready_in(ready0), .frame_err_out(fe0), .overrun_out(ov0),
        .fifo_count_out(count0)
    );

    uart_receive_fifo #(
        .INPUT_CLOCK_FREQ(100_000_000), .BAUD_RATE(1_000_000), .DATA_WIDTH(8),
        .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) u_even (
        .clk_in(clk_in), .rst_in(rst_in), .rx_wire_in(rx1),
        .data_out(data1), .parity_err_out(perr1), .valid_out(valid1),
        .ready_in(ready1), .frame_err_out(fe1), .overrun_out(ov1),
        .fifo_count_out(count1)
    );

    // Monitor for the no-parity instance
    always @(negedge clk_in) begin
        if (!rst_in && valid0 && ready0) begin
            checks++;
            if (exp0.size() == 0) begin
                errors++;
                $display("FAIL word0_unexpected: got %h, expected no word", {perr0, data0});
            end else begin
                logic [8:0] e;
                e = exp0.pop_front();
                if ({perr0, data0} !== e) begin
                    errors++;
                    $display("FAIL word0: got perr/data %h, expected %h", {perr0, data0}, e);
                end
            end
        end
    end

    // Monitor for the even-parity instance
    always @(negedge clk_in) begin
        if (!rst_in && valid1 && ready1) begin
            checks++;
            if (exp1.size() == 0) begin
                errors++;
                $display("FAIL word1_unexpected: got %h, expected no word", {perr1, data1});
            end else begin
                logic [8:0] e;
                e = exp1.pop_front();
                if ({perr1, data1} !== e) begin
                    errors++;
                    $display("FAIL word1: got perr/data %h, expected %h", {perr1, data1}, e);
                end
            end
        end
    end

    // Error pulse counters
    always @(negedge clk_in) begin
        if (fe0) fe_cnt0++;
        if (fe1) fe_cnt1++;
        if (ov0) ov_cnt0++;
        if (ov1) ov_cnt1++;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic drive_bit(input int which, input logic b);
        if (which == 0) rx0 = b;
        else            rx1 = b;
        wait_cycles(BIT_CYC);
    endtask

    // Instance 0: 8N1. Instance 1: 8E2 with an explicit parity bit.
    task automatic send_frame(input int which, input logic [7:0] d,
                              input logic par_bit, input logic stop_val);
        drive_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
        if (which == 1) drive_bit(which, par_bit);
        drive_bit(which, stop_val);
        if (which == 1) drive_bit(which, 1'b1);
    endtask

    task automatic drain(input int which, input string name);
        for (int i = 0; i < 1000; i++) begin
            if ((which == 0 ? exp0.size() : exp1.size()) == 0) break;
            wait_cycles(1);
        end
        wait_cycles(3);
        check(name, (which == 0) ? exp0.size() : exp1.size(), 0);
    endtask

    initial begin
        rst_in = 1'b1;
        rx0 = 1'b1; rx1 = 1'b1;
        ready0 = 1'b1; ready1 = 1'b1;
        wait_cycles(5);
        check("reset_outputs0", {data0, perr0, valid0, fe0, ov0, count0}, 0);
        check("reset_outputs1", {data1, perr1, valid1, fe1, ov1, count1}, 0);
        rst_in = 1'b0;
        wait_cycles(20);

        // Back-to-back frames, no parity
        exp0.push_back({1'b0, 8'hA5});
        exp0.push_back({1'b0, 8'h3C});
        send_frame(0, 8'hA5, 1'b0, 1'b1);
        send_frame(0, 8'h3C, 1'b0, 1'b1);
        drain(0, "t1_drain");
        check("t1_frame_err", fe_cnt0, 0);
        check("t1_overrun", ov_cnt0, 0);
        check("t1_count", count0, 0);

        // Even parity: wrong then right parity bit, plus a good 0xA5
        exp1.push_back({1'b1, 8'h07});
        exp1.push_back({1'b0, 8'h07});
        exp1.push_back({1'b0, 8'hA5});
        send_frame(1, 8'h07, 1'b0, 1'b1);
        send_frame(1, 8'h07, 1'b1, 1'b1);
        send_frame(1, 8'hA5, 1'b0, 1'b1);
        drain(1, "t2_drain");
        check("t2_frame_err", fe_cnt1, 0);

        // Bad stop bit, then line held low
        send_frame(0, 8'hC3, 1'b0, 1'b0);
        wait_cycles(500);
        check("t3_one_frame_err", fe_cnt0, 1);
        check("t3_count", count0, 0);
        check("t3_valid", valid0, 0);
        rx0 = 1'b1;
        wait_cycles(200);
        exp0.push_back({1'b0, 8'h55});
        send_frame(0, 8'h55, 1'b0, 1'b1);
        drain(0, "t3_drain");
        check("t3_frame_err_after", fe_cnt0, 1);

        // Fill the FIFO, overrun on the fifth frame, then drain in order
        ready0 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            exp0.push_back({1'b0, 8'(i)});
            send_frame(0, 8'(i), 1'b0, 1'b1);
        end
        wait_cycles(20);
        check("t4_count_full", count0, 4);
        check("t4_no_overrun_yet", ov_cnt0, 0);
        send_frame(0, 8'h05, 1'b0, 1'b1);
        wait_cycles(20);
        check("t4_overrun", ov_cnt0, 1);
        check("t4_count_after", count0, 4);
        check("t4_head", data0, 8'h01);
        ready0 = 1'b1;
        drain(0, "t4_drain");
        check("t4_count_empty", count0, 0);

        // Short low glitch while idle
        rx0 = 1'b0;
        wait_cycles(30);
        rx0 = 1'b1;
        wait_cycles(300);
        check("t5_glitch_count", count0, 0);
        check("t5_glitch_frame_err", fe_cnt0, 1);
        check("t5_glitch_valid", valid0, 0);
`ifdef UART_RX_MAJORITY_EN
        // One-cycle inverted spike at the centre of data bit 2 of 0x5A (bit = 0)
        exp0.push_back({1'b0, 8'h5A});
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        rx0 = 1'b0;
        wait_cycles(51);
        rx0 = 1'b1;
        wait_cycles(1);
        rx0 = 1'b0;
        wait_cycles(48);
        for (int i = 3; i < 8; i++) begin
            logic [7:0] v;
            v = 8'h5A;
            drive_bit(0, v[i]);
        end
        drive_bit(0, 1'b1);
        drain(0, "t5_spike_drain");
`endif

        // Reset mid-frame with a word parked in the FIFO
        ready0 = 1'b0;
        send_frame(0, 8'h5A, 1'b0, 1'b1);
        wait_cycles(10);
        check("t6_count_before", count0, 1);
        rx0 = 1'b0;
        wait_cycles(BIT_CYC);
        rx0 = 1'b1;
        wait_cycles(250);
        rst_in = 1'b1;
        wait_cycles(3);
        check("t6_reset_outputs0", {data0, perr0, valid0, fe0, ov0, count0}, 0);
        check("t6_reset_outputs1", {data1, perr1, valid1, fe1, ov1, count1}, 0);
        ready0 = 1'b1;
        rst_in = 1'b0;
        wait_cycles(1000);
        check("t6_count_after_reset", count0, 0);
        exp0.push_back({1'b0, 8'h12});
        send_frame(0, 8'h12, 1'b0, 1'b1);
        drain(0, "t6_drain");
        check("t6_frame_err", fe_cnt0, 1);
        check("t6_overrun", ov_cnt0, 1);
        check("final_errs1", fe_cnt1 + ov_cnt1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
